sstv_vis_detect: RTL and testbench



---
 rtl/sstv_vis_if.sv | 21 ++
 rtl/sstv_vis_detect.sv | 199 +++++++++++++++++++
 tb/tb_sstv_vis_detect.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/sstv_vis_if.sv
// Bundle of the detector's data-path signals: tone estimate and abort input
// towards the detector, calibration/VIS results back to the frame decoder.
interface sstv_vis_if;
    logic        frame_active;
    logic [11:0] freq;
    logic        cal_active;
    logic        cal_ok;
    logic        vis_valid;
    logic [6:0]  vis_code;
    logic        vis_err;

    modport master (
        output frame_active, freq,
        input  cal_active, cal_ok, vis_valid, vis_code, vis_err
    );

    modport slave (
        input  frame_active, freq,
        output cal_active, cal_ok, vis_valid, vis_code, vis_err
    );
endinterface

// File: rtl/sstv_vis_detect.sv
// SSTV header detector: leader/break/leader calibration with tolerance windows,
// followed by an 8-bit (7 data + even parity) VIS code decode sampled mid-bit.
module sstv_vis_detect #(
    parameter int TICKS_PER_MS  = 100_000,
    parameter int FREQ_TOL      = 25,
    parameter int LEADER_MIN_MS = 250,
    parameter int BREAK_MIN_MS  = 5,
    parameter int BREAK_MAX_MS  = 20,
    parameter int BIT_MS        = 30,
    parameter int VIS_EN        = 1
) (
    input  logic      clk,
    input  logic      reset,
    sstv_vis_if.slave bus
);
    localparam logic [31:0] LT   = 32'(LEADER_MIN_MS * TICKS_PER_MS);
    localparam logic [31:0] BMIN = 32'(BREAK_MIN_MS * TICKS_PER_MS);
    localparam logic [31:0] BMAX = 32'(BREAK_MAX_MS * TICKS_PER_MS);
    localparam logic [31:0] BT   = 32'(BIT_MS * TICKS_PER_MS);
    localparam logic [31:0] HB   = BT / 32'd2;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LEADER_A = 3'd1;
    localparam logic [2:0] S_BREAK    = 3'd2;
    localparam logic [2:0] S_LEADER_B = 3'd3;
    localparam logic [2:0] S_START    = 3'd4;
    localparam logic [2:0] S_DATA     = 3'd5;
    localparam logic [2:0] S_STOP     = 3'd6;

    // Tone centres, index 0..3 = 1900, 1200, 1100 (bit 1), 1300 (bit 0).
    localparam logic [51:0] TONES = {13'd1300, 13'd1100, 13'd1200, 13'd1900};

    logic [12:0] freq_ext;
    logic [3:0]  match;
    logic        m_1900, m_1200, m_1100, m_1300;

    assign freq_ext = {1'b0, bus.freq};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_tone
            localparam logic [12:0] CENTER = TONES[gi*13 +: 13];
            assign match[gi] = (freq_ext >= CENTER - 13'(FREQ_TOL)) &&
                               (freq_ext <= CENTER + 13'(FREQ_TOL));
        end
    endgenerate

    assign m_1900 = match[0];
    assign m_1200 = match[1];
    assign m_1100 = match[2];
    assign m_1300 = match[3];

    logic [2:0]  state_reg, state_next;
    logic [31:0] cnt_reg, cnt_next, cnt_inc;
    logic [2:0]  bit_idx_reg, bit_idx_next;
    logic [7:0]  shift_reg, shift_next;
    logic        cal_active_reg;
    logic        cal_ok_reg, cal_ok_next;
    logic [6:0]  code_reg, code_next;
    logic        valid_reg, valid_next;
    logic        err_reg, err_next;

    assign cnt_inc = (&cnt_reg) ? cnt_reg : cnt_reg + 32'd1;

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        bit_idx_next = bit_idx_reg;
        shift_next   = shift_reg;
        cal_ok_next  = cal_ok_reg;
        code_next    = code_reg;
        valid_next   = 1'b0;
        err_next     = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (m_1900 && !bus.frame_active) begin
                    state_next  = S_LEADER_A;
                    cal_ok_next = 1'b0;
                end
            end
            S_LEADER_A: begin
                if (m_1900)                    cnt_next   = cnt_inc;
                else if (m_1200 && cnt_reg >= LT) state_next = S_BREAK;
                else                           state_next = S_IDLE;
            end
            S_BREAK: begin
                if (m_1200) begin
                    cnt_next = cnt_inc;
                    if (cnt_inc >= BMAX) state_next = S_IDLE;
                end else if (m_1900 && cnt_reg >= BMIN) begin
                    state_next = S_LEADER_B;
                end else begin
                    state_next = S_IDLE;
                end
            end
            S_LEADER_B: begin
                if (m_1900) begin
                    cnt_next = cnt_inc;
                end else begin
                    state_next = S_IDLE;
                    if (cnt_reg >= LT) begin
                        if (VIS_EN != 0) begin
                            if (m_1200) begin
                                state_next  = S_START;
                                cal_ok_next = 1'b1;
                            end
                        end else begin
                            cal_ok_next = 1'b1;
                        end
                    end
                end
            end
            S_START: begin
                cnt_next = cnt_inc;
                if (cnt_reg == HB && !m_1200) begin
                    err_next   = 1'b1;
                    state_next = S_IDLE;
                end else if (cnt_reg == BT) begin
                    state_next   = S_DATA;
                    bit_idx_next = 3'd0;
                end
            end
            S_DATA: begin
                cnt_next = cnt_inc;
                if (cnt_reg == HB) begin
                    // LSB arrives first, so shifting in at the top leaves bit 0 at [0].
                    if (m_1100)      shift_next = {1'b1, shift_reg[7:1]};
                    else if (m_1300) shift_next = {1'b0, shift_reg[7:1]};
                    else begin
                        err_next   = 1'b1;
                        state_next = S_IDLE;
                    end
                end else if (cnt_reg == BT) begin
                    if (bit_idx_reg == 3'd7) begin
                        state_next = S_STOP;
                    end else begin
                        bit_idx_next = bit_idx_reg + 3'd1;
                        cnt_next     = 32'd1;
                    end
                end
            end
            S_STOP: begin
                cnt_next = cnt_inc;
                if (cnt_reg == HB) begin
                    state_next = S_IDLE;
                    if (m_1200 && !(^shift_reg)) begin
                        valid_next = 1'b1;
                        code_next  = shift_reg[6:0];
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase

        // The frame decoder owning the channel overrides everything silently.
        if (state_reg != S_IDLE && bus.frame_active) begin
            state_next  = S_IDLE;
            valid_next  = 1'b0;
            err_next    = 1'b0;
            cal_ok_next = cal_ok_reg;
            code_next   = code_reg;
        end

        if (state_next != state_reg) cnt_next = 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= S_IDLE;
            cnt_reg        <= 32'd1;
            bit_idx_reg    <= 3'd0;
            shift_reg      <= 8'd0;
            cal_active_reg <= 1'b0;
            cal_ok_reg     <= 1'b0;
            code_reg       <= 7'd0;
            valid_reg      <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            bit_idx_reg    <= bit_idx_next;
            shift_reg      <= shift_next;
            cal_active_reg <= (state_next != S_IDLE);
            cal_ok_reg     <= cal_ok_next;
            code_reg       <= code_next;
            valid_reg      <= valid_next;
            err_reg        <= err_next;
        end
    end

    assign bus.cal_active = cal_active_reg;
    assign bus.cal_ok     = cal_ok_reg;
    assign bus.vis_valid  = valid_reg;
    assign bus.vis_code   = code_reg;
    assign bus.vis_err    = err_reg;
endmodule

// File: tb/tb_sstv_vis_detect.sv
// Directed bench for sstv_vis_detect at TICKS_PER_MS=10; a queue-based
// scoreboard matches every vis_valid/vis_err pulse against the expected list.
module tb_sstv_vis_detect;
    logic clk;
    logic reset;

    sstv_vis_if bus0 ();
    sstv_vis_if bus1 ();

    assign bus1.freq         = bus0.freq;
    assign bus1.frame_active = bus0.frame_active;

    sstv_vis_detect #(.TICKS_PER_MS(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    sstv_vis_detect #(.TICKS_PER_MS(10), .VIS_EN(0)) dut_cal (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    typedef struct packed {
        logic       is_err;
        logic [6:0] code;
    } exp_t;

    exp_t exp_q[$];
    int   checks     = 0;
    int   errors     = 0;
    int   cal_pulses = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Scoreboard monitor: every output pulse must match the head of the queue.
    always @(negedge clk) begin
        if (!reset && (bus0.vis_valid || bus0.vis_err)) begin
            exp_t e;
            checks++;
            if (bus0.vis_valid && bus0.vis_err) begin
                errors++;
                $display("FAIL pulse_overlap actual=valid+err required=one");
            end else if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse actual valid=%0b err=%0b code=%0h required=none",
                         bus0.vis_valid, bus0.vis_err, bus0.vis_code);
            end else begin
                e = exp_q.pop_front();
                if (e.is_err != bus0.vis_err ||
                    (!e.is_err && e.code != bus0.vis_code)) begin
                    errors++;
                    $display("FAIL pulse actual err=%0b code=%0h required err=%0b code=%0h",
                             bus0.vis_err, bus0.vis_code, e.is_err, e.code);
                end else begin
                    $display("pulse t=%0t err=%0b code=%0h ok", $time, bus0.vis_err, bus0.vis_code);
                end
            end
        end
        if (!reset && (bus1.vis_valid || bus1.vis_err)) cal_pulses++;
    end

    task automatic hold(input int f, input int n);
        bus0.freq = 12'(f);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_header(input int off);
        hold(1900 + off, 3000);
        hold(1200 + off, 100);
        hold(1900 + off, 3000);
    endtask

    task automatic send_bit(input int off, input logic b);
        hold(b ? 1100 + off : 1300 + off, 300);
    endtask

    task automatic send_vis(input int off, input logic [6:0] code, input logic flip);
        logic par;
        par = ^code;
        if (flip) par = ~par;
        send_header(off);
        hold(1200 + off, 300);
        for (int i = 0; i < 7; i++) send_bit(off, code[i]);
        send_bit(off, par);
        hold(1200 + off, 300);
        hold(0, 10);
    endtask

    initial begin
        logic seen;
        reset = 1'b1;
        bus0.freq = 12'd0;
        bus0.frame_active = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_cal_active", 32'(bus0.cal_active), 0);
        check("reset_cal_ok",     32'(bus0.cal_ok), 0);
        check("reset_vis_valid",  32'(bus0.vis_valid), 0);
        check("reset_vis_err",    32'(bus0.vis_err), 0);
        check("reset_vis_code",   32'(bus0.vis_code), 0);
        reset = 1'b0;
        hold(0, 5);

        // Nominal 0x2C
        exp_q.push_back('{is_err: 1'b0, code: 7'h2C});
        send_vis(0, 7'h2C, 1'b0);
        check("nominal_cal_ok", 32'(bus0.cal_ok), 1);
        check("nominal_code", 32'(bus0.vis_code), 32'h2C);

        // Second pattern 0x55
        exp_q.push_back('{is_err: 1'b0, code: 7'h55});
        send_vis(0, 7'h55, 1'b0);
        check("code55_code", 32'(bus0.vis_code), 32'h55);

        // Tolerance edge +25
        exp_q.push_back('{is_err: 1'b0, code: 7'h2C});
        send_vis(25, 7'h2C, 1'b0);
        check("tol25_code", 32'(bus0.vis_code), 32'h2C);
        check("tol25_cal_ok", 32'(bus0.cal_ok), 1);

        // Just outside the window: never leaves IDLE
        seen = 1'b0;
        bus0.freq = 12'd1926;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            if (bus0.cal_active) seen = 1'b1;
        end
        check("tol26_cal_active", 32'(seen), 0);
        hold(0, 5);

        // Short leader
        hold(1900, 2000);
        check("short_active_before", 32'(bus0.cal_active), 1);
        check("short_cal_ok_cleared", 32'(bus0.cal_ok), 0);
        hold(1200, 1);
        check("short_active_after", 32'(bus0.cal_active), 0);
        hold(0, 5);

        // Long break: IDLE after the 199th BREAK cycle
        hold(1900, 3000);
        hold(1200, 199);
        check("longbrk_active_199", 32'(bus0.cal_active), 1);
        hold(1200, 1);
        check("longbrk_active_200", 32'(bus0.cal_active), 0);
        hold(1200, 50);
        check("longbrk_cal_ok", 32'(bus0.cal_ok), 0);
        hold(0, 5);

        // Good 0x2C then parity error
        exp_q.push_back('{is_err: 1'b0, code: 7'h2C});
        send_vis(0, 7'h2C, 1'b0);
        exp_q.push_back('{is_err: 1'b1, code: 7'h00});
        send_vis(0, 7'h2C, 1'b1);
        check("parity_code_held", 32'(bus0.vis_code), 32'h2C);
        check("parity_cal_ok", 32'(bus0.cal_ok), 1);

        // frame_active abort in LEADER_B
        hold(1900, 3000);
        hold(1200, 100);
        hold(1900, 1000);
        bus0.frame_active = 1'b1;
        @(posedge clk);
        #1;
        check("abort_cal_active", 32'(bus0.cal_active), 0);
        bus0.frame_active = 1'b0;
        hold(0, 20);
        check("abort_idle_stays", 32'(bus0.cal_active), 0);

        // Header followed by 1500 Hz: calibration-only instance reports cal_ok
        send_header(0);
        hold(1500, 20);
        check("calonly_cal_ok", 32'(bus1.cal_ok), 1);
        check("calonly_main_cal_ok", 32'(bus0.cal_ok), 0);
        check("calonly_main_active", 32'(bus0.cal_active), 0);
        hold(0, 5);

        // Reset while in DATA
        send_header(0);
        hold(1200, 300);
        send_bit(0, 1'b0);
        send_bit(0, 1'b0);
        hold(1100, 100);
        check("pre_reset_cal_ok", 32'(bus0.cal_ok), 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus0.freq = 12'd0;
        check("rst_cal_active", 32'(bus0.cal_active), 0);
        check("rst_cal_ok",     32'(bus0.cal_ok), 0);
        check("rst_vis_code",   32'(bus0.vis_code), 0);
        check("rst_vis_valid",  32'(bus0.vis_valid), 0);
        check("rst_vis_err",    32'(bus0.vis_err), 0);
        hold(0, 20);

        check("queue_drained", 32'(exp_q.size()), 0);
        check("calonly_no_pulses", 32'(cal_pulses), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
